// File: rtl/kernel_config_ctrl_pkg.sv
// Shared definitions for the kernel configuration controller: filter codes,
// preset kernels/divisors, the committed-config record and the entry FSM states.
package kernel_cfg_pkg;

    localparam int unsigned COEF_W_DEF = 3;
    localparam int unsigned NTAPS_DEF  = 9;
    localparam int unsigned DIV_W_DEF  = 7;
    localparam int unsigned KERN_W_DEF = COEF_W_DEF * NTAPS_DEF;

    localparam logic [2:0] FLT_ID     = 3'd0;
    localparam logic [2:0] FLT_INV    = 3'd1;
    localparam logic [2:0] FLT_BLUR   = 3'd2;
    localparam logic [2:0] FLT_BRIGHT = 3'd3;
    localparam logic [2:0] FLT_CUST   = 3'd4;

    // Taps are listed tap 8 first so tap 0 lands in the low bits.
    localparam logic [KERN_W_DEF-1:0] KERN_IDENTITY =
        {3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
    localparam logic [KERN_W_DEF-1:0] KERN_BLUR =
        {3'd1, 3'd2, 3'd1, 3'd2, 3'd4, 3'd2, 3'd1, 3'd2, 3'd1};
    localparam logic [KERN_W_DEF-1:0] KERN_BRIGHT =
        {3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0};

    localparam logic [DIV_W_DEF-1:0] DIV_ONE    = 7'd1;
    localparam logic [DIV_W_DEF-1:0] DIV_BLUR   = 7'd16;
    localparam logic [DIV_W_DEF-1:0] DIV_BRIGHT = 7'd2;

    typedef enum logic [1:0] {
        ST_PRESET = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_READY  = 2'd2
    } cfg_state_e;

    typedef struct packed {
        logic [KERN_W_DEF-1:0] kernel;
        logic [DIV_W_DEF-1:0]  divide;
        logic                  invert;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{kernel: KERN_IDENTITY, divide: DIV_ONE, invert: 1'b0};

    // Filter codes 5-7 fall through to identity.
    function automatic cfg_t preset_cfg(input logic [2:0] filter);
        cfg_t c;
        c = CFG_RESET;
        case (filter)
            FLT_INV:    c.invert = 1'b1;
            FLT_BLUR:   begin c.kernel = KERN_BLUR;   c.divide = DIV_BLUR;   end
            FLT_BRIGHT: begin c.kernel = KERN_BRIGHT; c.divide = DIV_BRIGHT; end
            default:    ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/kernel_config_ctrl_if.sv
// Switch/button inputs and committed datapath configuration of kernel_config_ctrl.
interface kernel_config_ctrl_if #(
    parameter int unsigned COEF_W = 3,
    parameter int unsigned NTAPS  = 9,
    parameter int unsigned DIV_W  = 7
);
    logic [2:0]              filter;
    logic [COEF_W-1:0]       k_in;
    logic                    store;
    logic                    div;
    logic                    frame_start;
    logic [NTAPS*COEF_W-1:0] kernel_out;
    logic [DIV_W-1:0]        divide_out;
    logic                    invert_out;
    logic                    cfg_update;
    logic [NTAPS-1:0]        led_store;
    logic                    led_display;

    modport slave (
        input  filter, k_in, store, div, frame_start,
        output kernel_out, divide_out, invert_out, cfg_update, led_store, led_display
    );

    modport master (
        output filter, k_in, store, div, frame_start,
        input  kernel_out, divide_out, invert_out, cfg_update, led_store, led_display
    );
endinterface

// File: rtl/kernel_config_ctrl_button_debounce.sv
// Button conditioner: 2-FF synchronizer, optional debounce (STORE_DEBOUNCE_EN),
// and a registered one-cycle pulse per rising edge.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic pulse_q, pulse_d;
    logic level;

`ifdef STORE_DEBOUNCE_EN
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;

    // Level follows the synchronized input only after it has differed for
    // DEBOUNCE_CYCLES consecutive cycles; agreeing again restarts the count.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign level = db_q;
`else
    assign level = sync2_q;
`endif

    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        prev_d  = level;
        pulse_d = level & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;
endmodule

// File: rtl/kernel_config_ctrl.sv
// Kernel configuration controller: preset decode, custom-kernel entry FSM and
// frame-aligned commit. Store-button debounce is enabled by STORE_DEBOUNCE_EN.
module kernel_config_ctrl
    import kernel_cfg_pkg::*;
#(
    parameter int unsigned COEF_W          = COEF_W_DEF,
    parameter int unsigned NTAPS           = NTAPS_DEF,
    parameter int unsigned DIV_W           = DIV_W_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input logic                 clk,
    input logic                 rst,
    kernel_config_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NTAPS);
    localparam int unsigned SUM_W = 6;

    logic                         store_pulse;
    cfg_state_e                   state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [NTAPS-1:0][COEF_W-1:0] custom_q, custom_d;
    logic [NTAPS-1:0]             led_store_q, led_store_d;
    logic [SUM_W-1:0]             coef_sum;
    logic [DIV_W-1:0]             cust_div;
    cfg_t                         pend_q, pend_d;
    cfg_t                         out_q, out_d;
    logic                         cfg_update_q, cfg_update_d;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_store_db (
        .clk  (clk),
        .rst_n(rst),
        .btn  (bus.store),
        .pulse(store_pulse)
    );

    // Leaving filter 4 overrides everything, so a capture on that cycle is dropped.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        custom_d    = custom_q;
        led_store_d = led_store_q;
        if (bus.filter != FLT_CUST) begin
            state_d     = ST_PRESET;
            idx_d       = '0;
            led_store_d = '0;
        end else begin
            unique case (state_q)
                ST_PRESET: begin
                    state_d     = ST_ENTRY;
                    idx_d       = '0;
                    led_store_d = '0;
                    custom_d    = '0;
                end
                ST_ENTRY: begin
                    if (store_pulse) begin
                        custom_d[idx_q]    = bus.k_in;
                        led_store_d[idx_q] = 1'b1;
                        if (idx_q == IDX_W'(NTAPS - 1)) begin
                            state_d = ST_READY;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_READY: ;
                default:  state_d = ST_PRESET;
            endcase
        end
    end

    always_comb begin
        coef_sum = '0;
        for (int unsigned i = 0; i < NTAPS; i++) begin
            coef_sum = coef_sum + SUM_W'(custom_q[i]);
        end
        cust_div = (bus.div && (coef_sum != '0)) ? DIV_W'(coef_sum) : DIV_W'(1);

        pend_d = CFG_RESET;
        if (bus.filter != FLT_CUST) begin
            pend_d = preset_cfg(bus.filter);
        end else if (state_q == ST_READY) begin
            pend_d.kernel = custom_q;
            pend_d.divide = cust_div;
        end
    end

    // Commit takes the pending value registered before this edge, so a pending
    // change landing on a frame_start cycle waits for the following frame.
    always_comb begin
        out_d        = out_q;
        cfg_update_d = 1'b0;
        if (bus.frame_start) begin
            out_d        = pend_q;
            cfg_update_d = (pend_q != out_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_PRESET;
            idx_q        <= '0;
            custom_q     <= '0;
            led_store_q  <= '0;
            pend_q       <= CFG_RESET;
            out_q        <= CFG_RESET;
            cfg_update_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            custom_q     <= custom_d;
            led_store_q  <= led_store_d;
            pend_q       <= pend_d;
            out_q        <= out_d;
            cfg_update_q <= cfg_update_d;
        end
    end

    assign bus.kernel_out  = out_q.kernel;
    assign bus.divide_out  = out_q.divide;
    assign bus.invert_out  = out_q.invert;
    assign bus.cfg_update  = cfg_update_q;
    assign bus.led_store   = led_store_q;
    assign bus.led_display = (state_q == ST_READY);
endmodule

// File: tb/tb_kernel_config_ctrl.sv
// Directed bench for kernel_config_ctrl with a cycle-level reference model.
module tb_kernel_config_ctrl;
    localparam int DB_N = 8;
`ifdef STORE_DEBOUNCE_EN
    localparam int DLY = 4;
`else
    localparam int DLY = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    kernel_config_ctrl_if #(.COEF_W(3), .NTAPS(9), .DIV_W(7)) bus ();

    kernel_config_ctrl #(
        .COEF_W(3), .NTAPS(9), .DIV_W(7), .DEBOUNCE_CYCLES(DB_N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [26:0] m_k, p_k;
    logic [6:0]  m_d, p_d;
    logic        m_i, p_i, m_upd;
    int          n_cap;          // -1: not in custom mode, 0..8 taps captured, 9: complete
    int          cust[9];
    bit   [7:0]  hist;           // store level per edge, bit 0 newest
    bit          filt;
    int          run;

    function automatic logic [26:0] pack_taps(input int t[9]);
        logic [26:0] v = '0;
        for (int i = 0; i < 9; i++) v[3*i +: 3] = 3'(t[i]);
        return v;
    endfunction

    task automatic model_preset(input logic [2:0] f, output logic [26:0] k,
                                output logic [6:0] d, output logic inv);
        int t[9];
        for (int i = 0; i < 9; i++) t[i] = 0;
        t[4] = 1; d = 7'd1; inv = 1'b0;
        if (f == 3'd1) inv = 1'b1;
        else if (f == 3'd2) begin t = '{1, 2, 1, 2, 4, 2, 1, 2, 1}; d = 7'd16; end
        else if (f == 3'd3) begin t[4] = 3; d = 7'd2; end
        k = pack_taps(t);
    endtask

    task automatic model_reset();
        model_preset(3'd0, m_k, m_d, m_i);
        p_k = m_k; p_d = m_d; p_i = m_i;
        m_upd = 1'b0; n_cap = -1; hist = '0; filt = 1'b0; run = 0;
        for (int i = 0; i < 9; i++) cust[i] = 0;
    endtask

    task automatic model_step();
        bit   lvl, cap;
        int   s;
        logic [26:0] nk; logic [6:0] nd; logic ni;
        lvl = bus.store;
`ifdef STORE_DEBOUNCE_EN
        if (bus.store != filt) begin
            run++;
            if (run == DB_N) begin filt = bus.store; run = 0; end
        end else run = 0;
        lvl = filt;
`endif
        hist = {hist[6:0], lvl};
        cap  = hist[DLY] && !hist[DLY+1];

        m_upd = bus.frame_start && ({p_k, p_d, p_i} != {m_k, m_d, m_i});
        if (bus.frame_start) begin m_k = p_k; m_d = p_d; m_i = p_i; end

        if (bus.filter != 3'd4) model_preset(bus.filter, nk, nd, ni);
        else if (n_cap == 9) begin
            s = 0;
            for (int i = 0; i < 9; i++) s += cust[i];
            nk = pack_taps(cust);
            nd = (bus.div && s != 0) ? 7'(s) : 7'd1;
            ni = 1'b0;
        end else model_preset(3'd0, nk, nd, ni);
        p_k = nk; p_d = nd; p_i = ni;

        if (bus.filter != 3'd4) n_cap = -1;
        else if (n_cap < 0) begin
            n_cap = 0;
            for (int i = 0; i < 9; i++) cust[i] = 0;
        end else if (n_cap < 9 && cap) begin
            cust[n_cap] = int'(bus.k_in);
            n_cap++;
        end
    endtask

    initial model_reset();
    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else model_step();
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        logic [8:0] exp_led;
        exp_led = (n_cap <= 0) ? 9'h000 : 9'((1 << n_cap) - 1);
        chk("kernel_out", 64'(bus.kernel_out), 64'(m_k));
        chk("divide_out", 64'(bus.divide_out), 64'(m_d));
        chk("invert_out", 64'(bus.invert_out), 64'(m_i));
        chk("cfg_update", 64'(bus.cfg_update), 64'(m_upd));
        chk("led_store", 64'(bus.led_store), 64'(exp_led));
        chk("led_display", 64'(bus.led_display), 64'(n_cap == 9));
    end

    // frame_start every 100 cycles, changed just after the edge like all stimulus
    initial begin
        bus.frame_start = 1'b0;
        forever begin
            @(posedge clk); #2;
            cyc++;
            bus.frame_start = (cyc % 100 == 99);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_commit();
        int  k = 0;
        bit  seen = 0;
        while (!seen && k < 300) begin
            @(posedge clk);
            k++;
            seen = bus.frame_start;
        end
        #2;
        @(negedge clk);
        chk("frame_start_seen", 64'(seen), 64'd1);
    endtask

    task automatic press(input logic [2:0] k);
        bus.k_in  = k;
        bus.store = 1'b1;
        tick(14);
        bus.store = 1'b0;
        tick(14);
    endtask

    task automatic count_updates(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.cfg_update === 1'b1) cnt++;
        end
        tick(1);
    endtask

    initial begin
        int cnt;
        logic [26:0] kl;
        bus.filter = 3'd0; bus.k_in = '0; bus.store = 1'b0; bus.div = 1'b0;
        tick(3);
        @(negedge clk);
        chk("rst_kernel", 64'(bus.kernel_out), 64'h0001000);
        chk("rst_divide", 64'(bus.divide_out), 64'd1);
        tick(1); rst = 1'b1; tick(5);

        // mid-frame reset after a brighten commit
        bus.filter = 3'd3; tick(2); wait_commit();
        chk("bright_kernel", 64'(bus.kernel_out), 64'h0003000);
        tick(30); rst = 1'b0;
        @(negedge clk);
        chk("midrst_kernel", 64'(bus.kernel_out), 64'h0001000);
        chk("midrst_divide", 64'(bus.divide_out), 64'd1);
        chk("midrst_invert", 64'(bus.invert_out), 64'd0);
        chk("midrst_led", 64'(bus.led_store), 64'd0);
        tick(2); rst = 1'b1;

        // blur preset: held until the frame boundary, single update pulse
        bus.filter = 3'd0; wait_commit(); tick(10);
        bus.filter = 3'd2; tick(5);
        @(negedge clk);
        chk("blur_held", 64'(bus.kernel_out), 64'h0001000);
        wait_commit();
        kl = {3'd1, 3'd2, 3'd1, 3'd2, 3'd4, 3'd2, 3'd1, 3'd2, 3'd1};
        chk("blur_kernel", 64'(bus.kernel_out), 64'(kl));
        chk("blur_divide", 64'(bus.divide_out), 64'd16);
        chk("blur_upd", 64'(bus.cfg_update), 64'd1);
        @(negedge clk);
        chk("blur_upd_once", 64'(bus.cfg_update), 64'd0);
        tick(1);

        bus.filter = 3'd1; tick(2); wait_commit();
        chk("inv_flag", 64'(bus.invert_out), 64'd1);
        tick(1);

        // custom kernel 1..7,1,1 with sum divisor
        bus.filter = 3'd4; bus.div = 1'b1; tick(3);
        for (int i = 0; i < 9; i++) begin
            press((i < 7) ? 3'(i + 1) : 3'd1);
            @(negedge clk);
            chk("led_walk", 64'(bus.led_store), 64'((1 << (i + 1)) - 1));
            tick(1);
        end
        @(negedge clk);
        chk("cust_display", 64'(bus.led_display), 64'd1);
        wait_commit();
        kl = {3'd1, 3'd1, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
        chk("cust_kernel", 64'(bus.kernel_out), 64'(kl));
        chk("cust_divide", 64'(bus.divide_out), 64'd30);
        tick(1);

        // all-zero kernel: divisor forced to 1, div toggle changes nothing
        bus.filter = 3'd0; tick(3); bus.filter = 3'd4; tick(3);
        for (int i = 0; i < 9; i++) press(3'd0);
        wait_commit();
        chk("zero_kernel", 64'(bus.kernel_out), 64'd0);
        chk("zero_divide", 64'(bus.divide_out), 64'd1);
        tick(1);
        bus.div = 1'b0;
        count_updates(150, cnt);
        chk("zero_div_toggle_upd", 64'(cnt), 64'd0);

        // abort entry after four taps
        bus.filter = 3'd0; tick(3); bus.filter = 3'd4; bus.div = 1'b1; tick(3);
        for (int i = 0; i < 4; i++) press(3'd2);
        @(negedge clk);
        chk("abort_led_before", 64'(bus.led_store), 64'h00F);
        tick(1);
        bus.filter = 3'd3; tick(1);
        @(negedge clk);
        chk("abort_led_cleared", 64'(bus.led_store), 64'd0);
        tick(2); wait_commit();
        chk("abort_kernel", 64'(bus.kernel_out), 64'h0003000);
        chk("abort_divide", 64'(bus.divide_out), 64'd2);
        tick(1);
        bus.filter = 3'd4; tick(3);
        press(3'd5);
        @(negedge clk);
        chk("restart_idx0", 64'(bus.led_store), 64'h001);
        tick(1);

`ifdef STORE_DEBOUNCE_EN
        bus.filter = 3'd0; tick(3); bus.filter = 3'd4; tick(3);
        bus.k_in = 3'd6;
        for (int i = 0; i < 3; i++) begin
            bus.store = 1'b1; tick(3); bus.store = 1'b0; tick(12);
        end
        @(negedge clk);
        chk("glitch_no_capture", 64'(bus.led_store), 64'd0);
        tick(1);
        bus.store = 1'b1; tick(10); bus.store = 1'b0; tick(20);
        @(negedge clk);
        chk("held_one_capture", 64'(bus.led_store), 64'h001);
        tick(1);
`endif

        tick(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/kernel_config_ctrl.md
Name: kernel_config_ctrl

Overview:
Configuration controller for the 3x3 convolution pixel datapath. It decodes the filter-select switches into a coefficient set, a divisor and an invert flag. It runs the user's custom-kernel entry sequence (9 coefficients keyed in with a store button) and commits the new configuration to the datapath only at frame boundaries, so a frame never tears. It sits between the board switches/buttons and the pixel datapath and runs on the 25 MHz VGA clock.

Parameters:
COEF_W, 3, bits per kernel coefficient (unsigned)
NTAPS, 9, kernel taps (3x3), row-major, tap 0 = top-left
DIV_W, 7, divisor width
DEBOUNCE_CYCLES, 250000, stable-input cycles required on store (10 ms at 25 MHz)

Ports:
clk  in  1  pixel clock (25 MHz)
rst  in  1  asynchronous active-low reset
filter  in  3  filter select: 0 identity, 1 invert, 2 blur, 3 brighten, 4 custom, 5-7 treated as identity
k_in  in  COEF_W  custom coefficient switches
store  in  1  raw store button, asynchronous, active-high
div  in  1  custom divisor mode: 1 = sum of coefficients, 0 = 1
frame_start  in  1  one-cycle pulse from VGA timing at start of vsync
kernel_out  out  NTAPS*COEF_W  committed coefficients; tap n at bits [n*COEF_W +: COEF_W]
divide_out  out  DIV_W  committed divisor, never 0
invert_out  out  1  committed invert-mode flag
cfg_update  out  1  one-cycle pulse on the cycle the outputs change
led_store  out  NTAPS  led_store[n] = 1 once custom tap n has been captured
led_display  out  1  1 while a complete custom kernel is pending or committed

Behaviour:
- Reset (async, rst low):
  - kernel_out = identity (tap 4 = 1, all others 0); divide_out = 1; invert_out = 0; cfg_update = 0.
  - led_store = 0; led_display = 0; state = PRESET; entry index = 0; custom registers = 0.
  - Pending registers take the same values as the outputs.
- Store conditioning: 2-FF synchronizer, then debounce, then rising-edge detect. This yields store_pulse, one cycle per press.
- FSM (registered), states PRESET, ENTRY, READY:
  - PRESET: pending config comes from the preset table. filter == 4 -> ENTRY with index = 0, led_store = 0, custom registers cleared, pending = identity with divide 1.
  - ENTRY: a store_pulse writes k_in to custom[index], sets led_store[index] and increments index. The pulse at index 8 goes to READY instead of incrementing. Pending stays identity throughout.
  - READY: pending kernel = custom registers; led_display = 1. store_pulse is ignored.
  - Any state, filter != 4 -> PRESET. This aborts entry and clears led_store and led_display the next cycle. Returning to 4 always restarts entry from index 0.
- Preset table (pending values):
  - identity and invert: tap 4 = 1, divide 1; invert flag = 1 for invert only.
  - blur: 1 2 1 / 2 4 2 / 1 2 1, divide 16.
  - brighten: tap 4 = 3, divide 2.
- Custom divisor:
  - div = 1: 6-bit sum of the 9 coefficients (max 63), zero-extended to DIV_W. A sum of 0 forces 1.
  - div = 0: divisor is 1.
  - div is re-evaluated every cycle while in READY.
- Commit: on a cycle with frame_start = 1, outputs load the pending registers as they stood before that edge. cfg_update pulses in the same cycle only if any output value changed.
- Simultaneous events:
  - A pending change and frame_start on the same cycle: the old pending value commits; the new one commits at the next frame_start.
  - store_pulse in the same cycle as a filter change away from 4: the filter change wins and the capture is discarded.
- Latency: filter or div change -> pending after 1 cycle -> outputs at the next frame_start.
- Outputs never change except at a frame_start or at reset.

Optional Feature:
STORE_DEBOUNCE_EN:
- Defined: store must be stable for DEBOUNCE_CYCLES consecutive cycles after synchronization before an edge is accepted. The counter restarts on any change.
- Undefined: only the synchronizer and edge detect remain. store_pulse follows the sync output rise by 1 cycle. Used for fast simulation; DEBOUNCE_CYCLES is unused.

Decomposition:
- Shared package kernel_cfg_pkg holds:
  - filter code constants (FLT_ID, FLT_INV, FLT_BLUR, FLT_BRIGHT, FLT_CUST);
  - the COEF_W/NTAPS/DIV_W defaults;
  - preset kernel and divisor constants;
  - the FSM state enum.
- One sub-module, button_debounce (synchronizer + optional debounce + rising-edge pulse), reused for other board buttons.

Test Plan (STORE_DEBOUNCE_EN undefined unless noted; frame_start every 100 cycles):
- Reset: assert rst low mid-frame -> kernel_out = 27'h000_1000 (tap 4 = 1), divide_out = 1, invert_out = 0, led_store = 0.
- Preset: filter = 2 -> no output change until the next frame_start; then kernel_out = {1,2,1,2,4,2,1,2,1}, divide_out = 16, cfg_update high for exactly 1 cycle.
- Custom with sum divisor: filter = 4, nine stores with k_in = 1..7,1,1, div = 1 -> led_store walks 0x001..0x1FF; led_display = 1; after frame_start divide_out = 30 and kernel_out matches the entered values.
- Zero sum: enter all zeros with div = 1 -> divide_out = 1; toggling div to 0 gives no cfg_update, since the value is unchanged.
- Abort: after 4 stores, set filter = 3 -> led_store = 0 next cycle; at frame_start kernel tap 4 = 3, divide 2; return to filter = 4 -> index restarts at 0.
- Debounce (macro defined, DEBOUNCE_CYCLES = 8): 3-cycle glitches on store produce no capture; a held 10-cycle press produces exactly one capture.
